match_select: RTL
=================

Name: match_select

Overview:
- Consumer end of the packed 1152-bit score bus produced by the formula calculation stage: 64 candidate blocks, 18 bits per block.
- On a start strobe it snapshots the bus and scans one block per clock. It tracks the best and second-best scores, then presents the winning block index (disparity), the scores and an ambiguity flag on a valid/ready output handshake.
- Sits between the per-block formula calculation stage and the distance/depth conversion logic.

Parameters:
- NBLK, 64, number of candidate blocks on the score bus.
- SW, 18, score width per block, in bits.
- IW, 6, index width; must equal clog2(NBLK).
- MARGIN, 18'd256, minimum best-minus-second gap below which a result is flagged ambiguous.

Ports:
- sig  input  1  clock; all logic on posedge sig.
- rst  input  1  synchronous reset, active-high.
- start  input  1  one-cycle request to capture result and begin a scan.
- result  input  NBLK*SW (1152)  packed scores; block k occupies bits [k*SW+SW-1 : k*SW].
- busy  output  1  high from start acceptance until the output handshake completes.
- out_valid  output  1  result fields valid; held until accepted.
- out_ready  input  1  downstream accept.
- best_idx  output  IW  index of the highest score.
- best_score  output  SW  highest score.
- second_score  output  SW  second-highest score.
- ambiguous  output  1  (best_score - second_score) < MARGIN.

Behaviour:
- Reset (rst=1 at posedge sig):
  - state=IDLE.
  - busy=0, out_valid=0, best_idx=0, best_score=0, second_score=0, ambiguous=0.
  - Shadow register and scan counter cleared.
  - Reset overrides everything, including mid-scan or mid-hold; an in-flight scan is discarded with no output.
- Scores are unsigned. Larger means better correlation.
- State IDLE:
  - If start=1: copy result into a shadow register, clear the counter and the running best/second/idx, set busy=1, go to SCAN.
  - Otherwise stay in IDLE.
- State SCAN: each cycle evaluate s = shadow block[cnt].
  - If s > best: second ← best, best ← s, idx ← cnt.
  - Else if s > second: second ← s.
  - The comparison is strict, so on ties the lowest index wins best. An equal score still updates second through the else branch.
  - cnt increments each cycle. After evaluating cnt=NBLK-1, register the outputs, compute ambiguous, set out_valid=1 and go to HOLD.
- Latency: start sampled at edge T; blocks evaluated at edges T+1..T+NBLK; out_valid is high after edge T+NBLK+1 (65 cycles for defaults).
- State HOLD:
  - All output fields are stable while out_valid=1.
  - When out_valid & out_ready at an edge: out_valid=0, busy=0, go to IDLE. Output fields keep their last values.
  - busy is still high during that handshake cycle, so start in the same cycle is ignored.
- start while busy=1 is ignored: no queueing, and the shadow is unaffected.
- Changes on result after capture have no effect on the current scan.
- ambiguous is computed from the final best/second, using a subtraction that cannot underflow because best ≥ second.
- All-equal scores give best_idx=0 and second_score=best_score, so ambiguous=1 when MARGIN>0.

Decomposition:
- Shared package: SW, NBLK, IW, the state encoding (IDLE/SCAN/HOLD), and a block-slice macro/function for packed-bus field extraction shared with the formula calculation stage.
- One natural sub-module: top2_tracker, the combinational/registered best/second/index update given (s, cnt), reusable for a left/right consistency check.

Test Plan:
- Reset then idle -> all outputs 0; busy=0 for 10 cycles with start=0.
- Block k = k*100, start pulse, out_ready=1 -> out_valid exactly 65 cycles after start; best_idx=63, best_score=6300, second_score=6200, ambiguous=1 (100<256).
- Block 5 = 5000, block 40 = 5000, block 12 = 4000, others 0 -> best_idx=5, best_score=5000, second_score=5000, ambiguous=1.
- Block 20 = 18'h3FFFF, block 3 = 1000, others 0, out_ready held 0 for 20 cycles -> outputs stable and out_valid=1 throughout; on out_ready=1 out_valid drops next edge; best_idx=20, ambiguous=0.
- Second start pulse at scan cycle 10 and result changed after capture -> ignored; output reflects the first snapshot only.
- rst asserted at scan cycle 30 -> next cycle busy=0 and out_valid=0; a fresh start then gives correct results with no stale best carried over.

Source files
------------

// File: rtl/match_select_pkg.sv
// Shared types and helpers for the score-bus consumer and its producer stage.
// Block k of the packed score bus sits at bits [k*SW +: SW].
package match_select_pkg;

  parameter int unsigned NBLK = 64;
  parameter int unsigned SW   = 18;
  parameter int unsigned IW   = 6;
  parameter int unsigned BW   = $clog2(NBLK * SW);

  localparam logic [SW-1:0] MARGIN = 18'd256;

  typedef enum logic [1:0] {
    StIdle,
    StScan,
    StHold
  } state_e;

  function automatic logic [SW-1:0] blk_slice(input logic [NBLK*SW-1:0] bus,
                                              input logic [IW-1:0]      k);
    logic [BW-1:0] base;
    base = BW'(k) * BW'(SW);
    return bus[base +: SW];
  endfunction

endpackage

// File: rtl/match_select_if.sv
// Start/score-bus request side plus the valid/ready result side of match_select.
interface match_select_if;
  import match_select_pkg::*;

  logic                 start;
  logic [NBLK*SW-1:0]   result;
  logic                 busy;
  logic                 out_valid;
  logic                 out_ready;
  logic [IW-1:0]        best_idx;
  logic [SW-1:0]        best_score;
  logic [SW-1:0]        second_score;
  logic                 ambiguous;

  modport slave (
    input  start, result, out_ready,
    output busy, out_valid, best_idx, best_score, second_score, ambiguous
  );

  modport master (
    output start, result, out_ready,
    input  busy, out_valid, best_idx, best_score, second_score, ambiguous
  );

endinterface

// File: rtl/match_select_top2_tracker.sv
// Running best/second-best tracker fed one (score, index) pair per enabled cycle.
// Strict compare: ties keep the earliest index as best and still lift second.
module match_select_top2_tracker
  import match_select_pkg::*;
(
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          clear_i,
  input  logic          en_i,
  input  logic [SW-1:0] s_i,
  input  logic [IW-1:0] cnt_i,
  output logic [SW-1:0] best_o,
  output logic [SW-1:0] second_o,
  output logic [IW-1:0] idx_o
);

  logic [SW-1:0] best_q, best_d;
  logic [SW-1:0] second_q, second_d;
  logic [IW-1:0] idx_q, idx_d;

  always_comb begin
    best_d   = best_q;
    second_d = second_q;
    idx_d    = idx_q;
    if (clear_i) begin
      best_d   = '0;
      second_d = '0;
      idx_d    = '0;
    end else if (en_i) begin
      if (s_i > best_q) begin
        second_d = best_q;
        best_d   = s_i;
        idx_d    = cnt_i;
      end else if (s_i > second_q) begin
        second_d = s_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      best_q   <= '0;
      second_q <= '0;
      idx_q    <= '0;
    end else begin
      best_q   <= best_d;
      second_q <= second_d;
      idx_q    <= idx_d;
    end
  end

  assign best_o   = best_q;
  assign second_o = second_q;
  assign idx_o    = idx_q;

endmodule

// File: rtl/match_select.sv
// Snapshots the packed score bus on start, scans one block per clock and presents
// the winning block index, top-two scores and an ambiguity flag on valid/ready.
module match_select
  import match_select_pkg::*;
(
  input  logic           sig,
  input  logic           rst,
  match_select_if.slave  bus
);

  localparam logic [IW-1:0] LastBlk = IW'(NBLK - 1);

  state_e             state_q, state_d;
  logic [IW-1:0]      cnt_q, cnt_d;
  logic [NBLK*SW-1:0] shadow_q, shadow_d;
  logic               out_valid_q, out_valid_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [SW-1:0]      best_q, best_d;
  logic [SW-1:0]      second_q, second_d;
  logic               amb_q, amb_d;

  logic               trk_clear;
  logic               trk_en;
  logic [SW-1:0]      trk_best;
  logic [SW-1:0]      trk_second;
  logic [IW-1:0]      trk_idx;

  assign trk_clear = (state_q == StIdle) && bus.start;
  assign trk_en    = (state_q == StScan);

  match_select_top2_tracker u_tracker (
    .clk_i    (sig),
    .rst_i    (rst),
    .clear_i  (trk_clear),
    .en_i     (trk_en),
    .s_i      (blk_slice(shadow_q, cnt_q)),
    .cnt_i    (cnt_q),
    .best_o   (trk_best),
    .second_o (trk_second),
    .idx_o    (trk_idx)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shadow_d    = shadow_q;
    out_valid_d = out_valid_q;
    idx_d       = idx_q;
    best_d      = best_q;
    second_d    = second_q;
    amb_d       = amb_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          shadow_d = bus.result;
          cnt_d    = '0;
          state_d  = StScan;
        end
      end
      StScan: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LastBlk) state_d = StHold;
      end
      StHold: begin
        // First HOLD cycle publishes the tracker's final state; afterwards wait for accept.
        if (!out_valid_q) begin
          idx_d       = trk_idx;
          best_d      = trk_best;
          second_d    = trk_second;
          amb_d       = (trk_best - trk_second) < MARGIN;
          out_valid_d = 1'b1;
        end else if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge sig) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      shadow_q    <= '0;
      out_valid_q <= 1'b0;
      idx_q       <= '0;
      best_q      <= '0;
      second_q    <= '0;
      amb_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shadow_q    <= shadow_d;
      out_valid_q <= out_valid_d;
      idx_q       <= idx_d;
      best_q      <= best_d;
      second_q    <= second_d;
      amb_q       <= amb_d;
    end
  end

  assign bus.busy         = (state_q != StIdle);
  assign bus.out_valid    = out_valid_q;
  assign bus.best_idx     = idx_q;
  assign bus.best_score   = best_q;
  assign bus.second_score = second_q;
  assign bus.ambiguous    = amb_q;

endmodule
